sha_block_sequencer: RTL

Controller that sequences a two-block (1024-bit) padded message through a single SHA-256 compression core. It accepts one message per handshake and splits it into block 0 (message[1023:512]) and block 1 (message[511:0]). Block 0 is compressed against the initial hash value, and block 1 against the resulting intermediate hash. The final 256-bit digest is returned on a valid/ready output. It sits between the message source (e.g. header formatter) and the compression core in the mining datapath.

---
 rtl/sha_block_sequencer_if.sv | 33 +++
 rtl/sha_block_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sha_block_sequencer_if.sv
// rtl/sha_block_sequencer_if.sv - message, core and digest channels of the SHA block sequencer
interface sha_block_sequencer_if;
    logic          msg_valid;
    logic          msg_ready;
    logic [1023:0] message;

    logic          core_start;
    logic [511:0]  core_block;
    logic [255:0]  core_hash_in;
    logic          core_done;
    logic [255:0]  core_hash_out;

    logic          digest_valid;
    logic          digest_ready;
    logic [255:0]  digest;

    logic          busy;
    logic          protocol_err;

    // Sequencer side
    modport slave (
        input  msg_valid, message, core_done, core_hash_out, digest_ready,
        output msg_ready, core_start, core_block, core_hash_in,
               digest_valid, digest, busy, protocol_err
    );

    // Environment side: message source, compression core and digest consumer
    modport master (
        output msg_valid, message, core_done, core_hash_out, digest_ready,
        input  msg_ready, core_start, core_block, core_hash_in,
               digest_valid, digest, busy, protocol_err
    );
endinterface

// File: rtl/sha_block_sequencer.sv
// rtl/sha_block_sequencer.sv - two-block SHA-256 message sequencer around one compression core
module sha_block_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    sha_block_sequencer_if.slave bus
);
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_START1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [1023:0] msg_q;
    logic [255:0]  chain_q;
    logic [255:0]  digest_q;
    logic          err_q;

    logic          accept;
    logic          in_wait;

    logic          msg_ready_c;
    logic          core_start_c;
    logic [511:0]  core_block_c;
    logic [255:0]  core_hash_in_c;
    logic          digest_valid_c;
    logic          busy_c;

    // msg_ready is decoded from state, so acceptance is simply IDLE plus a valid message
    assign accept  = (state == S_IDLE) && bus.msg_valid;
    assign in_wait = (state == S_WAIT0) || (state == S_WAIT1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs; core inputs stay on the bus from START through WAIT
    always_comb begin
        state_nx       = state;
        msg_ready_c    = 1'b0;
        core_start_c   = 1'b0;
        core_block_c   = '0;
        core_hash_in_c = '0;
        digest_valid_c = 1'b0;
        busy_c         = 1'b1;
        case (state)
            S_IDLE: begin
                msg_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (bus.msg_valid) begin
                    state_nx = S_START0;
                end
            end
            S_START0: begin
                core_start_c   = 1'b1;
                core_block_c   = msg_q[1023:512];
                core_hash_in_c = IV;
                state_nx       = S_WAIT0;
            end
            S_WAIT0: begin
                core_block_c   = msg_q[1023:512];
                core_hash_in_c = IV;
                if (bus.core_done) begin
                    state_nx = S_START1;
                end
            end
            S_START1: begin
                core_start_c   = 1'b1;
                core_block_c   = msg_q[511:0];
                core_hash_in_c = chain_q;
                state_nx       = S_WAIT1;
            end
            S_WAIT1: begin
                core_block_c   = msg_q[511:0];
                core_hash_in_c = chain_q;
                if (bus.core_done) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                digest_valid_c = 1'b1;
                if (bus.digest_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Message register only loads on acceptance, so it is frozen for the whole two-block run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q <= '0;
        end else if (accept) begin
            msg_q <= bus.message;
        end
    end

    // Intermediate chaining value after block 0, final digest after block 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q  <= '0;
            digest_q <= '0;
        end else begin
            if ((state == S_WAIT0) && bus.core_done) begin
                chain_q <= bus.core_hash_out;
            end
            if ((state == S_WAIT1) && bus.core_done) begin
                digest_q <= bus.core_hash_out;
            end
        end
    end

    // Sticky flag for a core_done pulse the sequencer was not waiting for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.core_done && !in_wait) begin
            err_q <= 1'b1;
        end
    end

    assign bus.msg_ready    = msg_ready_c;
    assign bus.core_start   = core_start_c;
    assign bus.core_block   = core_block_c;
    assign bus.core_hash_in = core_hash_in_c;
    assign bus.digest_valid = digest_valid_c;
    assign bus.digest       = digest_q;
    assign bus.busy         = busy_c;
    assign bus.protocol_err = err_q;
endmodule
